// File: rtl/maxbw_pkg.sv
// rtl/maxbw_pkg.sv - shared constants and types for the DDR fold accumulator
package maxbw_pkg;

    // Fold operator encoding on the mode input; MODE_RSVD folds as XOR.
    localparam logic [1:0] MODE_XOR  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_OR   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    // PRBS7 x^7 + x^6 + 1: next bit is the XOR of the two oldest history bits.
    localparam int PRBS7_LEN   = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    function automatic logic prbs7_predict(input logic [PRBS7_LEN-1:0] hist);
        return hist[PRBS7_TAP_A] ^ hist[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/ddr_fold_accum_if.sv
// rtl/ddr_fold_accum_if.sv - data/control/result bundle of the DDR fold accumulator
// master: drives in_data, mode, start, out_ready (the source/consumer side)
// slave : drives busy, out_data, out_valid, overrun, err_count (the accumulator)
interface ddr_fold_accum_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in_data;
    logic [1:0]       mode;
    logic             start;
    logic             busy;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic [7:0]       err_count;

    modport master (
        output in_data, mode, start, out_ready,
        input  busy, out_data, out_valid, overrun, err_count
    );

    modport slave (
        input  in_data, mode, start, out_ready,
        output busy, out_data, out_valid, overrun, err_count
    );
endinterface

// File: rtl/ddr_capture.sv
// rtl/ddr_capture.sv - rising/falling edge capture pair for a DDR input bus
// clk     : in_lo loads on the rising edge, in_hi on the falling edge
// in_data : pad-side DDR bus
// in_lo   : half captured on the rising edge
// in_hi   : half captured on the following falling edge
module ddr_capture #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic [IN_W-1:0] in_data,
    output logic [IN_W-1:0] in_lo,
    output logic [IN_W-1:0] in_hi
);

    // Pad capture flops carry no reset; the beat is only consumed under FSM control.
    always_ff @(posedge clk) begin
        in_lo <= in_data;
    end

    always_ff @(negedge clk) begin
        in_hi <= in_data;
    end

endmodule

// File: rtl/ddr_fold_accum.sv
// rtl/ddr_fold_accum.sv - DDR ingress fold/accumulate signature over a 2^WIN_LOG2 beat window
// Optional PRBS7 checker on bit 0 of each half-beat: define MAXBW_PRBS_CHECK_EN.
// clk, rst : single clock, synchronous active-high reset
// bus      : in_data/mode/start in, busy/out_data/out_valid/overrun/err_count out,
//            out_ready in (valid/ready result handshake)
module ddr_fold_accum
    import maxbw_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 8,
    parameter int WIN_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    ddr_fold_accum_if.slave   bus
);

    localparam int NSLICE = 2 * IN_W / OUT_W;
    localparam int CNT_W  = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << WIN_LOG2) - 1);

    logic [IN_W-1:0]    in_lo;
    logic [IN_W-1:0]    in_hi;
    logic [2*IN_W-1:0]  beat;
    logic [OUT_W-1:0]   fold;
    logic [OUT_W-1:0]   acc_q;
    logic [OUT_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         mode_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q;
    logic               overrun_q;
    state_t             state_q;
    state_t             state_d;
    logic               start_ok;
    logic               ovr_set;
    logic               accept;

    ddr_capture #(.IN_W(IN_W)) u_cap (
        .clk     (clk),
        .in_data (bus.in_data),
        .in_lo   (in_lo),
        .in_hi   (in_hi)
    );

    function automatic logic [OUT_W-1:0] apply_op(
        input logic [1:0]       m,
        input logic [OUT_W-1:0] a,
        input logic [OUT_W-1:0] b
    );
        case (m)
            MODE_ADD: return a + b;
            MODE_OR:  return a | b;
            default:  return a ^ b;
        endcase
    endfunction

    // Zero is the identity of all three operators, so the fold can seed from it.
    assign beat = {in_hi, in_lo};

    always_comb begin
        fold = '0;
        for (int i = 0; i < NSLICE; i++) begin
            fold = apply_op(mode_q, fold, beat[i*OUT_W +: OUT_W]);
        end
    end

    assign acc_next = apply_op(mode_q, acc_q, fold);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        ovr_set  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_ACCUM;
                    start_ok = 1'b1;
                end
            end
            ST_ACCUM: begin
                ovr_set = bus.start;
                if (cnt_q == LAST) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (bus.start) begin
                        state_d  = ST_ACCUM;
                        start_ok = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ovr_set = bus.start;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_XOR;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end
            if (accept) begin
                out_valid_q <= 1'b0;
            end
            if (start_ok) begin
                acc_q  <= '0;
                cnt_q  <= '0;
                mode_q <= bus.mode;
            end else if (state_q == ST_ACCUM) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    out_data_q  <= acc_next;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state_q == ST_ACCUM);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

`ifdef MAXBW_PRBS_CHECK_EN
    logic [PRBS7_LEN-1:0] hist_q;
    logic [PRBS7_LEN-1:0] hist_mid;
    logic [PRBS7_LEN-1:0] hist_d;
    logic                 err_lo;
    logic                 err_hi;
    logic [8:0]           err_sum;
    logic [7:0]           err_q;

    // Two bits per beat, in_lo first: the second prediction sees in_lo already shifted in.
    always_comb begin
        err_lo   = in_lo[0] ^ prbs7_predict(hist_q);
        hist_mid = {hist_q[PRBS7_LEN-2:0], in_lo[0]};
        err_hi   = in_hi[0] ^ prbs7_predict(hist_mid);
        hist_d   = {hist_mid[PRBS7_LEN-2:0], in_hi[0]};
        err_sum  = {1'b0, err_q} + {8'd0, err_lo} + {8'd0, err_hi};
    end

    // Self-synchronising: the history always follows the line, only counting is gated.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (start_ok) begin
            err_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_ddr_fold_accum.sv
// tb/tb_ddr_fold_accum.sv - randomized self-checking bench for ddr_fold_accum
module tb_ddr_fold_accum;
    import maxbw_pkg::*;

    localparam int IN_W     = 16;
    localparam int OUT_W    = 8;
    localparam int WIN_LOG2 = 4;
    localparam int N        = 1 << WIN_LOG2;
    localparam int NS       = 2 * IN_W / OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ddr_fold_accum_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifc  ();
    ddr_fold_accum_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifc1 ();

    ddr_fold_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .WIN_LOG2(WIN_LOG2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    ddr_fold_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .WIN_LOG2(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    assign ifc1.in_data   = ifc.in_data;
    assign ifc1.mode      = ifc.mode;
    assign ifc1.start     = ifc.start;
    assign ifc1.out_ready = ifc.out_ready;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IN_W-1:0] lo_q [N];
    logic [IN_W-1:0] hi_q [N];
    logic [6:0]      mh = '0;
    logic [6:0]      g  = 7'h01;
    bit              prbs_on = 1'b0;
    bit              cnt_en  = 1'b0;
    int              m_err   = 0;
    bit              m_ovr   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] next_word();
        logic [IN_W-1:0] w;
        logic            b;
        w = IN_W'($urandom);
        if (prbs_on) begin
            b    = g[6] ^ g[5];
            g    = {g[5:0], b};
            w[0] = b;
        end
        return w;
    endfunction

    // Reference PRBS checker: predicts each received bit from the two oldest of the last seven.
    task automatic prbs_bit(input logic b);
        if (cnt_en && (b != (mh[6] ^ mh[5])) && m_err < 255) m_err++;
        mh = {mh[5:0], b};
    endtask

    // One beat: lo is presented for the rising edge, hi for the falling edge.
    task automatic step(input logic [IN_W-1:0] lo, input logic [IN_W-1:0] hi);
        ifc.in_data = lo;
        @(posedge clk);
        #1;
        ifc.in_data = hi;
        @(negedge clk);
        #1;
        prbs_bit(lo[0]);
        prbs_bit(hi[0]);
    endtask

    task automatic step_rand();
        logic [IN_W-1:0] lo, hi;
        lo = next_word();
        hi = next_word();
        step(lo, hi);
    endtask

    task automatic idle(input int n, input bit force_rdy);
        for (int k = 0; k < n; k++) begin
            ifc.start     = 1'b0;
            ifc.mode      = 2'($urandom);
            ifc.out_ready = force_rdy ? 1'b1 : 1'($urandom);
            step_rand();
        end
        ifc.out_ready = 1'b0;
    endtask

    task automatic fill_const(input logic [IN_W-1:0] lo, input logic [IN_W-1:0] hi);
        for (int k = 0; k < N; k++) begin
            lo_q[k] = lo;
            hi_q[k] = hi;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            lo_q[k] = next_word();
            hi_q[k] = next_word();
        end
    endtask

    // Operators are associative, so the window result is the op over every slice of every beat.
    function automatic logic [OUT_W-1:0] model_result(input logic [1:0] md, input int n);
        logic [2*IN_W-1:0] b;
        logic [OUT_W-1:0]  v;
        logic [OUT_W-1:0]  r;
        int unsigned       sum;
        r   = '0;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            b = {hi_q[k], lo_q[k]};
            for (int s = 0; s < NS; s++) begin
                v = OUT_W'(b >> (s * OUT_W));
                if (md == 2'b01)      sum = sum + 32'(v);
                else if (md == 2'b10) r = r | v;
                else                  r = r ^ v;
            end
        end
        if (md == 2'b01) r = OUT_W'(sum);
        return r;
    endfunction

    // poke: 0 none, 1 start during HOLD backpressure, 2 start mid-accumulation.
    task automatic do_window(input logic [1:0] md, input int hold, input int poke,
                             input bit started, input bit chain, input bit refill,
                             input bit w0, input logic [1:0] next_md);
        logic [OUT_W-1:0] exp, exp0;
        int               exp_err;
        exp  = model_result(md, N);
        exp0 = model_result(md, 1);
        if (!started) begin
            ifc.mode      = md;
            ifc.start     = 1'b1;
            ifc.out_ready = 1'b0;
            m_err  = 0;
            cnt_en = 1'b1;
            step(lo_q[0], hi_q[0]);
        end
        check_val("busy_after_start", 32'(ifc.busy), 32'd1);
        ifc.start = 1'b0;
        for (int i = 1; i < N; i++) begin
            ifc.mode      = 2'($urandom);
            ifc.out_ready = 1'($urandom);
            ifc.start     = (poke == 2 && i == N / 2);
            if (ifc.start) m_ovr = 1'b1;
            step(lo_q[i], hi_q[i]);
            ifc.start = 1'b0;
            if (w0 && i == 1) begin
                check_val("w0_valid", 32'(ifc1.out_valid), 32'd1);
                check_val("w0_data", 32'(ifc1.out_data), 32'(exp0));
            end
        end
        cnt_en = 1'b0;
`ifdef MAXBW_PRBS_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        check_val("valid_early", 32'(ifc.out_valid), 32'd0);
        check_val("busy_last", 32'(ifc.busy), 32'd1);
        ifc.out_ready = 1'b0;
        step_rand();
        check_val("valid_at_n", 32'(ifc.out_valid), 32'd1);
        check_val("out_data", 32'(ifc.out_data), 32'(exp));
        check_val("busy_done", 32'(ifc.busy), 32'd0);
        check_val("err_count", 32'(ifc.err_count), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            ifc.start = (poke == 1 && h == hold / 2);
            if (ifc.start) m_ovr = 1'b1;
            step_rand();
            ifc.start = 1'b0;
            check_val("hold_valid", 32'(ifc.out_valid), 32'd1);
            check_val("hold_data", 32'(ifc.out_data), 32'(exp));
        end
        check_val("overrun", 32'(ifc.overrun), 32'(m_ovr));
        ifc.out_ready = 1'b1;
        ifc.start     = chain;
        if (chain) begin
            ifc.mode = next_md;
            if (refill) fill_random();
            m_err  = 0;
            cnt_en = 1'b1;
            step(lo_q[0], hi_q[0]);
        end else begin
            step_rand();
        end
        ifc.out_ready = 1'b0;
        ifc.start     = 1'b0;
        check_val("valid_cleared", 32'(ifc.out_valid), 32'd0);
        check_val("busy_b2b", 32'(ifc.busy), 32'(chain));
        check_val("data_kept", 32'(ifc.out_data), 32'(exp));
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy", 32'(ifc.busy), 32'd0);
        check_val("rst_out_data", 32'(ifc.out_data), 32'd0);
        check_val("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check_val("rst_overrun", 32'(ifc.overrun), 32'd0);
        check_val("rst_err_count", 32'(ifc.err_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] md, nmd;
        bit         started, chain;

        ifc.in_data   = '0;
        ifc.mode      = 2'b00;
        ifc.start     = 1'b0;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle(3, 1'b0);
        rst = 1'b0;
        check_reset_outputs();
        idle(5, 1'b0);

        // ADD over constant beats
        fill_const(16'h0102, 16'h0304);
        do_window(MODE_ADD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, MODE_ADD);

        // XOR, with the 1-beat instance checked alongside
        idle(2, 1'b1);
        do_window(MODE_XOR, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, MODE_XOR);

        // OR with a single set bit in the falling half of beat 3
        idle(1, 1'b0);
        fill_const(16'h0000, 16'h0000);
        hi_q[3] = 16'h8000;
        do_window(MODE_OR, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, MODE_OR);

        // Backpressure with a lost start in HOLD
        idle(1, 1'b0);
        fill_random();
        do_window(MODE_ADD, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0, MODE_ADD);

        // Back-to-back identical windows
        idle(1, 1'b0);
        fill_const(16'h0102, 16'h0304);
        do_window(MODE_ADD, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, MODE_ADD);
        do_window(MODE_ADD, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, MODE_ADD);

        // Random windows, including reserved mode, mid-window starts and chaining
        started = 1'b0;
        md      = 2'($urandom);
        for (int w = 0; w < 10; w++) begin
            if (!started) begin
                md = 2'($urandom);
                idle($urandom_range(0, 2), 1'b0);
                fill_random();
            end
            chain = (w < 9) ? 1'($urandom) : 1'b0;
            nmd   = 2'($urandom);
            do_window(md, $urandom_range(0, 3), $urandom_range(0, 2), started, chain, 1'b1, 1'b0, nmd);
            started = chain;
            md      = nmd;
        end

        // Reset part-way through an ADD window, then a clean rerun
        idle(1, 1'b0);
        fill_const(16'h0102, 16'h0304);
        ifc.mode  = MODE_ADD;
        ifc.start = 1'b1;
        step(lo_q[0], hi_q[0]);
        ifc.start = 1'b0;
        for (int i = 1; i < 7; i++) step(lo_q[i], hi_q[i]);
        rst = 1'b1;
        step(lo_q[7], hi_q[7]);
        rst    = 1'b0;
        m_ovr  = 1'b0;
        m_err  = 0;
        cnt_en = 1'b0;
        check_reset_outputs();
        idle(5, 1'b0);
        check_val("no_valid_after_rst", 32'(ifc.out_valid), 32'd0);
        fill_const(16'h0102, 16'h0304);
        do_window(MODE_ADD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, MODE_ADD);

        // PRBS7 on bit 0: clean stream, then a single flipped bit
        prbs_on = 1'b1;
        idle(6, 1'b0);
        fill_random();
        do_window(MODE_XOR, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, MODE_XOR);
        idle(6, 1'b0);
        fill_random();
        lo_q[2][0] = ~lo_q[2][0];
        do_window(MODE_ADD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, MODE_ADD);
        prbs_on = 1'b0;

        idle(2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
